// File: rtl/weight_bank_buffer.sv
// Double-buffered weight/bias store: the DDR read stage fills one bank while
// the convolution core reads the other. Banks hand over on completion/release.
module weight_bank_buffer #(
  parameter int MEM_DATA_WIDTH  = 512,
  parameter int BANK_DEPTH      = 256,
  parameter int BANK_ADDR_WIDTH = 8
) (
  input  logic                       system_clk,
  input  logic                       rst,
  input  logic                       task_start,
  input  logic [MEM_DATA_WIDTH-1:0]  weight_and_bias_data,
  input  logic                       weight_and_bias_valid,
  output logic                       weight_buffer_ready,
  output logic                       bank_valid,
  input  logic                       rd_en,
  input  logic [BANK_ADDR_WIDTH-1:0] rd_addr,
  output logic [MEM_DATA_WIDTH-1:0]  rd_data,
  output logic                       rd_data_valid,
  input  logic                       bank_release,
  output logic [15:0]                banks_loaded,
  output logic                       overflow
);

  // Both banks live in one array; the bank bit is the top address bit.
  logic [MEM_DATA_WIDTH-1:0]  mem [2*BANK_DEPTH];

  logic [1:0]                 full;
  logic [1:0]                 full_next;
  logic                       wr_bank;
  logic                       rd_bank;
  logic [BANK_ADDR_WIDTH-1:0] wr_cnt;

  logic                       wr_accept;
  logic                       wr_last;
  logic                       rel_accept;
  logic                       rd_accept;

  assign weight_buffer_ready = ~full[wr_bank];
  assign bank_valid          = full[rd_bank];

  // Qualify the incoming write, read and release requests against bank state.
  always_comb begin
    wr_accept  = weight_and_bias_valid & ~full[wr_bank] & ~task_start;
    wr_last    = wr_accept && (wr_cnt == BANK_ADDR_WIDTH'(BANK_DEPTH - 1));
    rel_accept = bank_release & full[rd_bank];
    rd_accept  = rd_en & full[rd_bank] & ~task_start;
  end

  // Next full flags: release clears first, completion sets last, so a bank
  // that is both completed and released in one cycle stays full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    full_next = full;
    if (rel_accept) full_next[rd_bank] = 1'b0;
    if (wr_last)    full_next[wr_bank] = 1'b1;
  end

  // Storage write port.
  always_ff @(posedge system_clk) begin
    // NOTE: the storage array is deliberately left out of reset so it maps
    // onto block RAM; the full flags alone say which contents are meaningful.
    if (wr_accept) mem[{wr_bank, wr_cnt}] <= weight_and_bias_data;
  end

  // Bank pointers, fill counter, status flags and registered read port.
  always_ff @(posedge system_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      full          <= 2'b00;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      banks_loaded  <= 16'd0;
      overflow      <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else if (task_start) begin
      // rd_data keeps its last word; only the valid strobe is cleared.
      full          <= 2'b00;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      banks_loaded  <= 16'd0;
      overflow      <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      full <= full_next;

      if (wr_accept) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) begin
          wr_bank      <= ~wr_bank;
          banks_loaded <= banks_loaded + 16'd1;
        end
      end else if (weight_and_bias_valid) begin
        // A write into a full bank is dropped, even if that bank is being
        // released this same cycle: ready was already low.
        overflow <= 1'b1;
      end

      if (rel_accept) rd_bank <= ~rd_bank;

      rd_data_valid <= rd_accept;
      if (rd_accept) rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_weight_bank_buffer.sv
// Directed bench for weight_bank_buffer: fill, read, overflow, release,
// same-cycle hand-over, task_start and mid-burst reset.
module tb_weight_bank_buffer;

  localparam int W  = 512;
  localparam int AW = 8;

  logic          system_clk = 1'b0;
  logic          rst;
  logic          task_start;
  logic [W-1:0]  weight_and_bias_data;
  logic          weight_and_bias_valid;
  logic          weight_buffer_ready;
  logic          bank_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_data_valid;
  logic          bank_release;
  logic [15:0]   banks_loaded;
  logic          overflow;

  int n_checks = 0;
  int n_fails  = 0;

  weight_bank_buffer dut (
    .system_clk            (system_clk),
    .rst                   (rst),
    .task_start            (task_start),
    .weight_and_bias_data  (weight_and_bias_data),
    .weight_and_bias_valid (weight_and_bias_valid),
    .weight_buffer_ready   (weight_buffer_ready),
    .bank_valid            (bank_valid),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .rd_data               (rd_data),
    .rd_data_valid         (rd_data_valid),
    .bank_release          (bank_release),
    .banks_loaded          (banks_loaded),
    .overflow              (overflow)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      weight_and_bias_valid = 1'b1;
      weight_and_bias_data  = W'(base + i);
      @(negedge system_clk);
    end
    weight_and_bias_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input int exp);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    @(negedge system_clk);
    rd_en   = 1'b0;
    check({tag, "_valid"}, W'(rd_data_valid), W'(1));
    check({tag, "_data"}, rd_data, W'(exp));
  endtask

  task automatic release_bank();
    bank_release = 1'b1;
    @(negedge system_clk);
    bank_release = 1'b0;
  endtask

  task automatic start_task();
    task_start = 1'b1;
    @(negedge system_clk);
    task_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    task_start = 1'b0;
    weight_and_bias_data = '0;
    weight_and_bias_valid = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    bank_release = 1'b0;
    repeat (3) @(negedge system_clk);

    // Reset state.
    check("rst_full", W'(dut.full), W'(0));
    check("rst_wr_cnt", W'(dut.wr_cnt), W'(0));
    check("rst_loaded", W'(banks_loaded), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    check("rst_rd_data", rd_data, W'(0));
    check("rst_rd_valid", W'(rd_data_valid), W'(0));
    rst = 1'b0;
    @(negedge system_clk);
    check("post_rst_ready", W'(weight_buffer_ready), W'(1));
    check("post_rst_bank_valid", W'(bank_valid), W'(0));

    // One full bank, word i = i.
    write_words(256, 0);
    check("b0_full", W'(dut.full), W'(2'b01));
    check("b0_bank_valid", W'(bank_valid), W'(1));
    check("b0_ready", W'(weight_buffer_ready), W'(1));
    check("b0_loaded", W'(banks_loaded), W'(1));
    read_check("rd5", 5, 5);
    @(negedge system_clk);
    check("rd_valid_drop", W'(rd_data_valid), W'(0));
    read_check("rd255", 255, 255);
    read_check("rd16", 16, 16);

    // Second bank, then one extra word overflows.
    write_words(256, 1000);
    check("both_full", W'(dut.full), W'(2'b11));
    check("both_ready", W'(weight_buffer_ready), W'(0));
    check("both_loaded", W'(banks_loaded), W'(2));
    write_words(1, 'hDEAD);
    check("ovf_flag", W'(overflow), W'(1));
    check("ovf_wr_cnt", W'(dut.wr_cnt), W'(0));
    check("ovf_loaded", W'(banks_loaded), W'(2));
    read_check("ovf_rd0", 0, 0);

    // Release bank 0; reads come from bank 1.
    release_bank();
    check("rel_rd_bank", W'(dut.rd_bank), W'(1));
    check("rel_full", W'(dut.full), W'(2'b10));
    check("rel_ready", W'(weight_buffer_ready), W'(1));
    read_check("rel_rd0", 0, 1000);
    read_check("rel_rd255", 255, 1255);

    // task_start clears state.
    start_task();
    check("ts_full", W'(dut.full), W'(0));
    check("ts_overflow", W'(overflow), W'(0));
    check("ts_loaded", W'(banks_loaded), W'(0));
    check("ts_rd_bank", W'(dut.rd_bank), W'(0));

    // Completion into bank 1 together with release of bank 0.
    write_words(256, 2000);
    write_words(255, 3000);
    weight_and_bias_valid = 1'b1;
    weight_and_bias_data  = W'(3255);
    bank_release = 1'b1;
    @(negedge system_clk);
    weight_and_bias_valid = 1'b0;
    bank_release = 1'b0;
    check("same_full", W'(dut.full), W'(2'b10));
    check("same_rd_bank", W'(dut.rd_bank), W'(1));
    check("same_wr_bank", W'(dut.wr_bank), W'(0));
    check("same_loaded", W'(banks_loaded), W'(2));
    read_check("same_rd255", 255, 3255);

    // Fill bank 0 again; a write in the cycle bank 1 is released is dropped.
    write_words(256, 4000);
    check("refill_full", W'(dut.full), W'(2'b11));
    weight_and_bias_valid = 1'b1;
    weight_and_bias_data  = W'(4444);
    bank_release = 1'b1;
    @(negedge system_clk);
    weight_and_bias_valid = 1'b0;
    bank_release = 1'b0;
    check("relwr_overflow", W'(overflow), W'(1));
    check("relwr_wr_cnt", W'(dut.wr_cnt), W'(0));
    check("relwr_full", W'(dut.full), W'(2'b01));
    read_check("relwr_rd0", 0, 4000);

    // task_start after a partial burst.
    start_task();
    write_words(100, 9000);
    check("part_wr_cnt", W'(dut.wr_cnt), W'(100));
    start_task();
    check("part_ts_wr_cnt", W'(dut.wr_cnt), W'(0));
    check("part_ts_full", W'(dut.full), W'(0));
    check("part_ts_loaded", W'(banks_loaded), W'(0));
    write_words(256, 5000);
    check("part_full", W'(dut.full), W'(2'b01));
    check("part_loaded", W'(banks_loaded), W'(1));
    read_check("part_rd0", 0, 5000);
    read_check("part_rd99", 99, 5099);

    // Read and release with nothing full.
    start_task();
    rd_en = 1'b1;
    rd_addr = 8'd3;
    @(negedge system_clk);
    rd_en = 1'b0;
    check("empty_rd_valid", W'(rd_data_valid), W'(0));
    check("empty_rd_hold", rd_data, W'(5099));
    release_bank();
    check("empty_rel_full", W'(dut.full), W'(0));
    check("empty_rel_rd_bank", W'(dut.rd_bank), W'(0));

    // task_start wins over a simultaneous write.
    weight_and_bias_valid = 1'b1;
    weight_and_bias_data  = W'(1);
    task_start = 1'b1;
    @(negedge system_clk);
    weight_and_bias_valid = 1'b0;
    task_start = 1'b0;
    check("ts_prio_wr_cnt", W'(dut.wr_cnt), W'(0));

    // Asynchronous reset mid-burst discards the partial bank.
    write_words(50, 6000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wr_cnt", W'(dut.wr_cnt), W'(0));
    check("async_rst_rd_data", rd_data, W'(0));
    @(negedge system_clk);
    rst = 1'b0;
    write_words(256, 7000);
    check("post_rst_full", W'(dut.full), W'(2'b01));
    check("post_rst_wr_bank", W'(dut.wr_bank), W'(1));
    read_check("post_rst_rd0", 0, 7000);
    read_check("post_rst_rd49", 49, 7049);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
